// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
   typedef enum logic {OWN_I, OWN_D} arb_owner_t;

endpackage

// File: rtl/mem_arb_streak_ctr.sv
// Counts consecutive data grants made while a fetch is waiting;
// at_max tells the arbiter to let the fetch through next.
module mem_arb_streak_ctr #(
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic grant_d,
   input  logic grant_i,
   input  logic i_req,
   input  logic i_pending,
   output logic at_max
);

   localparam int unsigned CNT_W = $clog2(MAX_D_STREAK + 1);

   logic [CNT_W-1:0] count;

   assign at_max = (count == CNT_W'(MAX_D_STREAK));

   // A D grant with i_req high but killed neither extends nor breaks the streak.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (grant_i) begin
         count <= '0;
      end else if (grant_d) begin
         if (!i_req)
            count <= '0;
         else if (i_pending && !at_max)
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory port between fetch and data requesters; data wins.
// Define MEM_ARB_FAIRNESS_EN to bound how long a fetch can be starved by data.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W       = mem_arb_pkg::ADDR_W,
   parameter int unsigned DATA_W       = mem_arb_pkg::DATA_W,
   parameter int unsigned MAX_D_STREAK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_kill,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_valid,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_accept,
   input  logic              m_resp_valid,
   input  logic [DATA_W-1:0] m_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   import mem_arb_pkg::*;

   if (MAX_D_STREAK < 1) begin : g_bad_cfg
      $error("MAX_D_STREAK must be at least 1");
   end

   arb_state_t state;
   arb_owner_t owner;
   logic       kill;
   logic       i_ready_r;
   logic       i_pending;
   logic       fair_i;
   logic       grant_i;
   logic       grant_d;
   logic       kill_now;

   assign i_pending = i_req && !i_kill;

`ifdef MEM_ARB_FAIRNESS_EN
   logic at_max;

   mem_arb_streak_ctr #(.MAX_D_STREAK(MAX_D_STREAK)) u_streak (
      .clk       (clk),
      .reset     (reset),
      .grant_d   (grant_d),
      .grant_i   (grant_i),
      .i_req     (i_req),
      .i_pending (i_pending),
      .at_max    (at_max)
   );

   assign fair_i = at_max && i_pending;
`else
   assign fair_i = 1'b0;
`endif

   assign grant_d  = (state == IDLE) && d_req && !fair_i;
   assign grant_i  = (state == IDLE) && (fair_i || (!d_req && i_pending));
   assign kill_now = kill || (owner == OWN_I && i_kill);

   // A kill landing in RESP still has to hide the already-registered pulse.
   assign i_ready   = i_ready_r && !i_kill;
   assign stall_if  = i_req && !i_ready;
   assign stall_mem = d_req && !d_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWN_I;
         kill      <= 1'b0;
         m_valid   <= 1'b0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         i_ready_r <= 1'b0;
         d_ready   <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_ready_r <= 1'b0;
         d_ready   <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  owner   <= OWN_D;
                  m_valid <= 1'b1;
                  m_we    <= d_we;
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
                  state   <= REQ;
               end else if (grant_i) begin
                  owner   <= OWN_I;
                  m_valid <= 1'b1;
                  m_we    <= 1'b0;
                  m_addr  <= i_addr;
                  m_wdata <= '0;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (owner == OWN_I && i_kill)
                  kill <= 1'b1;
               if (m_accept) begin
                  m_valid <= 1'b0;
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (m_resp_valid) begin
                  if (owner == OWN_I)
                     i_rdata <= m_rdata;
                  else
                     d_rdata <= m_rdata;
                  if (kill_now) begin
                     kill  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     i_ready_r <= (owner == OWN_I);
                     d_ready   <= (owner == OWN_D);
                     state     <= RESP;
                  end
               end else if (owner == OWN_I && i_kill) begin
                  kill <= 1'b1;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   resp_only_in_wait: assert property (
      @(posedge clk) disable iff (reset) m_resp_valid |-> (state == WAIT)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; grant order depends on MEM_ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_kill = 1'b0;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        m_valid;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_accept = 1'b1;
   logic        m_resp_valid = 1'b0;
   logic [31:0] m_rdata = '0;
   logic        stall_if;
   logic        stall_mem;

   int checks = 0;
   int failures = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_kill       (i_kill),
      .i_ready      (i_ready),
      .i_rdata      (i_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_ready      (d_ready),
      .d_rdata      (d_rdata),
      .m_valid      (m_valid),
      .m_we         (m_we),
      .m_addr       (m_addr),
      .m_wdata      (m_wdata),
      .m_accept     (m_accept),
      .m_resp_valid (m_resp_valid),
      .m_rdata      (m_rdata),
      .stall_if     (stall_if),
      .stall_mem    (stall_mem)
   );

   always #5 clk = ~clk;

   task tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a one-cycle memory response; caller ensures the DUT is in WAIT.
   task respond(input logic [31:0] data);
      m_resp_valid = 1'b1;
      m_rdata      = data;
      tick();
      m_resp_valid = 1'b0;
   endtask

   task wait_grant(output logic [31:0] addr, output bit ok);
      ok   = 1'b0;
      addr = '0;
      for (int i = 0; i < 20; i++) begin
         if (m_valid) begin
            addr = m_addr;
            ok   = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if ({m_valid, m_we, i_ready, d_ready} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_ctrl got=%b exp=0000", {m_valid, m_we, i_ready, d_ready});
      end
      checks++;
      if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'd0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", {m_addr, m_wdata, i_rdata, d_rdata});
      end
      reset = 1'b0;
      tick();
   endtask

   task test_lone_fetch();
      i_req  = 1'b1;
      i_addr = 32'h40;
      tick();
      checks++;
      if ({m_valid, m_we, m_addr} !== {1'b1, 1'b0, 32'h40}) begin
         failures++;
         $display("FAIL fetch_issue got v=%b we=%b a=%h exp v=1 we=0 a=40", m_valid, m_we, m_addr);
      end
      checks++;
      if (stall_if !== 1'b1) begin
         failures++;
         $display("FAIL fetch_stall_req got=%b exp=1", stall_if);
      end
      tick();
      checks++;
      if ({m_valid, i_ready, stall_if} !== 3'b001) begin
         failures++;
         $display("FAIL fetch_wait got v/rdy/stall=%b exp=001", {m_valid, i_ready, stall_if});
      end
      respond(32'h00A00093);
      checks++;
      if ({i_ready, stall_if, i_rdata} !== {1'b1, 1'b0, 32'h00A00093}) begin
         failures++;
         $display("FAIL fetch_ready got rdy=%b stall=%b d=%h exp rdy=1 stall=0 d=00a00093",
                  i_ready, stall_if, i_rdata);
      end
      i_req = 1'b0;
      tick();
      checks++;
      if ({i_ready, m_valid} !== 2'b00) begin
         failures++;
         $display("FAIL fetch_pulse_end got=%b exp=00", {i_ready, m_valid});
      end
   endtask

   task test_simultaneous();
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h100;
      d_wdata = 32'hDEADBEEF;
      i_req   = 1'b1;
      i_addr  = 32'h44;
      tick();
      checks++;
      if ({m_valid, m_we, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin
         failures++;
         $display("FAIL sim_store_first got v=%b we=%b a=%h w=%h exp 1 1 100 deadbeef",
                  m_valid, m_we, m_addr, m_wdata);
      end
      tick();
      respond(32'h0);
      checks++;
      if ({d_ready, i_ready, stall_mem, stall_if} !== 4'b1001) begin
         failures++;
         $display("FAIL sim_d_ready got rdy_d/rdy_i/st_m/st_i=%b exp=1001",
                  {d_ready, i_ready, stall_mem, stall_if});
      end
      d_req = 1'b0;
      d_we  = 1'b0;
      tick();
      checks++;
      if ({m_valid, d_ready} !== 2'b00) begin
         failures++;
         $display("FAIL sim_resp_no_grant got v/d_rdy=%b exp=00", {m_valid, d_ready});
      end
      tick();
      checks++;
      if ({m_valid, m_we, m_addr} !== {1'b1, 1'b0, 32'h44}) begin
         failures++;
         $display("FAIL sim_fetch_next got v=%b we=%b a=%h exp 1 0 44", m_valid, m_we, m_addr);
      end
      tick();
      respond(32'h11111111);
      checks++;
      if ({i_ready, i_rdata} !== {1'b1, 32'h11111111}) begin
         failures++;
         $display("FAIL sim_fetch_done got rdy=%b d=%h exp 1 11111111", i_ready, i_rdata);
      end
      i_req = 1'b0;
      tick();
   endtask

   task test_kill();
      i_req  = 1'b1;
      i_addr = 32'h48;
      tick();
      tick();
      i_kill = 1'b1;
      i_req  = 1'b0;
      tick();
      i_kill = 1'b0;
      respond(32'h12345678);
      checks++;
      if (i_ready !== 1'b0) begin
         failures++;
         $display("FAIL kill_no_ready got=%b exp=0", i_ready);
      end
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h300;
      tick();
      checks++;
      if ({m_valid, m_addr, i_ready} !== {1'b1, 32'h300, 1'b0}) begin
         failures++;
         $display("FAIL kill_back_idle got v=%b a=%h i_rdy=%b exp 1 300 0", m_valid, m_addr, i_ready);
      end
      tick();
      respond(32'hCAFEF00D);
      checks++;
      if ({d_ready, d_rdata} !== {1'b1, 32'hCAFEF00D}) begin
         failures++;
         $display("FAIL kill_then_load got rdy=%b d=%h exp 1 cafef00d", d_ready, d_rdata);
      end
      d_req = 1'b0;
      tick();
      // Kill arriving in the RESP cycle itself.
      i_req  = 1'b1;
      i_addr = 32'h4C;
      tick();
      tick();
      respond(32'h0BADF00D);
      i_kill = 1'b1;
      #1;
      checks++;
      if (i_ready !== 1'b0) begin
         failures++;
         $display("FAIL kill_in_resp got=%b exp=0", i_ready);
      end
      i_req = 1'b0;
      tick();
      i_kill = 1'b0;
   endtask

   task test_backpressure();
      bit stable;
      stable   = 1'b1;
      m_accept = 1'b0;
      d_req    = 1'b1;
      d_we     = 1'b0;
      d_addr   = 32'h200;
      tick();
      for (int c = 0; c < 6; c++) begin
         if ({m_valid, m_addr, d_ready} !== {1'b1, 32'h200, 1'b0}) stable = 1'b0;
         if (c < 5) tick();
      end
      checks++;
      if (stable !== 1'b1) begin
         failures++;
         $display("FAIL bp_stable got v=%b a=%h d_rdy=%b exp 1 200 0", m_valid, m_addr, d_ready);
      end
      m_accept = 1'b1;
      tick();
      checks++;
      if ({m_valid, d_ready} !== 2'b00) begin
         failures++;
         $display("FAIL bp_accepted got v/rdy=%b exp=00", {m_valid, d_ready});
      end
      respond(32'h55AA55AA);
      checks++;
      if ({d_ready, d_rdata} !== {1'b1, 32'h55AA55AA}) begin
         failures++;
         $display("FAIL bp_done got rdy=%b d=%h exp 1 55aa55aa", d_ready, d_rdata);
      end
      d_req = 1'b0;
      tick();
   endtask

   task test_reset_mid();
      logic [31:0] a;
      bit ok;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h500;
      tick();
      tick();
      reset        = 1'b1;
      m_resp_valid = 1'b1;
      m_rdata      = 32'h99999999;
      tick();
      reset        = 1'b0;
      m_resp_valid = 1'b0;
      d_req        = 1'b0;
      checks++;
      if ({m_valid, d_ready, d_rdata} !== {1'b0, 1'b0, 32'h0}) begin
         failures++;
         $display("FAIL rst_mid got v=%b rdy=%b d=%h exp 0 0 0", m_valid, d_ready, d_rdata);
      end
      tick();
      checks++;
      if ({m_valid, d_ready} !== 2'b00) begin
         failures++;
         $display("FAIL rst_mid_after got v/rdy=%b exp=00", {m_valid, d_ready});
      end
      i_req  = 1'b1;
      i_addr = 32'h80;
      tick();
      wait_grant(a, ok);
      checks++;
      if (!ok || a !== 32'h80) begin
         failures++;
         $display("FAIL rst_mid_resume got ok=%b a=%h exp ok=1 a=80", ok, a);
      end
      tick();
      respond(32'h0);
      i_req = 1'b0;
      tick();
   endtask

   task test_back_to_back();
      logic [31:0] a;
      logic [31:0] exp_a;
      bit ok;
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h600;
      i_req  = 1'b1;
      i_addr = 32'h700;
      for (int g = 0; g < 10; g++) begin
         wait_grant(a, ok);
`ifdef MEM_ARB_FAIRNESS_EN
         exp_a = (g % 5 == 4) ? 32'h700 : 32'h600;
`else
         exp_a = 32'h600;
`endif
         checks++;
         if (!ok || a !== exp_a) begin
            failures++;
            $display("FAIL grant_order_%0d got ok=%b a=%h exp a=%h", g, ok, a, exp_a);
         end
         if (!ok) break;
         tick();
         respond(32'h0);
         tick();
      end
      d_req = 1'b0;
      i_req = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      test_reset();
      test_lone_fetch();
      test_simultaneous();
      test_kill();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one multi-cycle memory port between the pipeline's instruction-fetch requester (read-only) and its data-memory requester (load/store).
- Sits between the IF and MEM stages and the unified backing memory.
- Drives stall signals so the hazard logic can freeze PC and IF/ID, or hold EX/MEM, while an access is outstanding.
- Default policy is fixed priority: data wins, because it belongs to the older instruction.

Parameters:
ADDR_W, 32, address width of all requesters and the memory port
DATA_W, 32, data width
MAX_D_STREAK, 4, consecutive data grants allowed while fetch waits (used only with MEM_ARB_FAIRNESS_EN)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_req  input  1  fetch request, level, held until i_ready
i_addr  input  ADDR_W  fetch address, stable while i_req
i_kill  input  1  squash fetch (branch/jump redirect)
i_ready  output  1  one-cycle pulse: i_rdata valid, fetch done
i_rdata  output  DATA_W  fetched word
d_req  input  1  data request, level, held until d_ready
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_ready  output  1  one-cycle pulse: access done, d_rdata valid for loads
d_rdata  output  DATA_W  load data
m_valid  output  1  request to memory
m_we  output  1  write enable to memory
m_addr  output  ADDR_W  memory address
m_wdata  output  DATA_W  memory write data
m_accept  input  1  memory accepts request this cycle (while m_valid)
m_resp_valid  input  1  memory response or write-ack, one cycle
m_rdata  input  DATA_W  memory read data
stall_if  output  1  i_req && !i_ready
stall_mem  output  1  d_req && !d_ready

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. An owner register (I or D) and a kill flag accompany the FSM.
- Reset: state IDLE; all of m_valid, m_we, i_ready, d_ready are 0; m_addr, m_wdata, i_rdata, d_rdata are 0; kill flag, owner and streak counter are cleared.
- IDLE: arbitrate in this cycle.
  - If d_req: owner = D.
  - Else if i_req && !i_kill: owner = I.
  - Else stay in IDLE.
  - On a grant, latch address, we and wdata into the output registers and go to REQ. For a fetch, m_we = 0.
- REQ: m_valid = 1 with the latched payload.
  - The payload is never changed or withdrawn before m_accept.
  - On m_accept go to WAIT; m_valid is 0 from the next cycle.
- WAIT: on m_resp_valid, capture m_rdata into the owner's rdata register.
  - If kill flag is set: go to IDLE and clear the kill flag.
  - Otherwise go to RESP.
- RESP: assert the owner's ready for exactly one cycle; rdata is valid this cycle and holds until the next capture. Next state is IDLE.
- RESP does not arbitrate. The requester still holds its old request during RESP, so granting there would repeat it.
- Minimum latency with accept in the first REQ cycle and the response in the first WAIT cycle: grant in cycle N, m_valid in N+1, response in N+2, ready in N+3, next arbitration in N+4.
- i_kill handling:
  - In IDLE, it blocks a fetch grant that cycle.
  - With owner = I in REQ or WAIT, it sets the kill flag. The request is still completed to memory, and the response is consumed silently with no i_ready.
  - In RESP with owner = I, it suppresses i_ready.
  - It has no effect on data accesses.
- Simultaneous d_req and i_req in IDLE: D is granted unless the fairness override below applies.
- m_resp_valid seen in IDLE, REQ or RESP is ignored (not legal; an assertion flags it).
- Reset mid-access: the FSM returns to IDLE immediately and any outstanding response is discarded. The memory shares the same reset.
- stall_if and stall_mem are combinational from the request inputs and the ready outputs.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- When defined, a streak counter (clog2(MAX_D_STREAK+1) bits) behaves as follows:
  - It increments on each D grant made while i_req && !i_kill.
  - It clears on any I grant.
  - It clears on a D grant made while i_req is low.
- When the count equals MAX_D_STREAK, the next IDLE arbitration grants I if i_req && !i_kill, even if d_req is set.
- When the macro is not defined, priority is strictly data over fetch and no counter is instantiated.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef arb_state_t {IDLE, REQ, WAIT, RESP}
  - typedef arb_owner_t {OWN_I, OWN_D}
  - default width constants ADDR_W and DATA_W
- One natural sub-module, mem_arb_streak_ctr: the fairness counter, instantiated only under MEM_ARB_FAIRNESS_EN.

Test Plan:
1. Lone fetch: i_addr=0x40, memory accepts at once and responds with 0x00A00093 one cycle later -> m_valid high one cycle with m_addr=0x40, m_we=0; i_ready pulses 3 cycles after the grant with i_rdata=0x00A00093; stall_if=1 until then.
2. Simultaneous requests: d_req store to addr 0x100 with wdata 0xDEADBEEF, and i_req at 0x44 in the same IDLE cycle -> store issued first (m_we=1); d_ready pulses; fetch is issued in the next IDLE cycle.
3. Kill mid-flight: fetch of 0x48 in WAIT, i_kill pulses -> response 0x12345678 consumed, no i_ready, FSM back in IDLE; the next d_req is granted normally.
4. Back-pressure: m_accept held low for 5 cycles during a load of 0x200 -> m_valid and m_addr=0x200 stay stable for all 6 cycles; d_ready pulses only after the response.
5. Reset in WAIT with owner = D -> the next cycle shows IDLE, m_valid=0, d_ready=0; a late m_resp_valid is ignored.
6. With MEM_ARB_FAIRNESS_EN, MAX_D_STREAK=4, d_req and i_req held continuously -> grant order D,D,D,D,I,D,...; without the macro, I is never granted while d_req=1.
